// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types: machine word, ALU opcodes, multiplier
//               sequencer states and the multiplier iteration count.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ABS_A  = 3'd1,
    ABS_B  = 3'd2,
    ITER   = 3'd3,
    NEG_LO = 3'd4,
    NEG_HI = 3'd5,
    DONE   = 3'd6
  } mulstate_t;

  localparam int MUL_ITERS = 32;

endpackage
`default_nettype wire

// File: rtl/alu_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_if
// Description : Connection bundle to the single-cycle ALU.
// Ports       : PORTA/PORTB/ALUOP - operands and operation into the ALU
//               OUTPORT/ZERO/OVF/NEG - result and flags out of the ALU
//               modport alu : the ALU itself
//               modport tb  : the block driving the ALU (alu_mult_ctrl)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_if;
  import cpu_types_pkg::*;

  word_t  PORTA;
  word_t  PORTB;
  aluop_t ALUOP;
  word_t  OUTPORT;
  logic   ZERO;
  logic   OVF;
  logic   NEG;

  modport alu (input PORTA, PORTB, ALUOP, output OUTPORT, ZERO, OVF, NEG);
  modport tb  (output PORTA, PORTB, ALUOP, input OUTPORT, ZERO, OVF, NEG);
endinterface
`default_nettype wire

// File: rtl/alu_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_mult_ctrl
// Description : Shares one ALU between the execute stage and an iterative
//               32x32 shift-add multiplier (MULT/MULTU), and sequences the
//               multiplier. The execute stage always has priority; any
//               multiplier step that needs the ALU waits until granted.
// Ports       : CLK, RST            - clock, synchronous active-high reset
//               ex_valid/porta/portb/aluop - execute-stage ALU request
//               ex_out/zero/ovf/neg - ALU result to execute (combinational)
//               mul_start/signed/a/b - multiply request (taken in IDLE only)
//               mul_busy, mul_done  - status; done is a one-cycle pulse
//               hi, lo              - last completed 64-bit product
//               aluif               - ALU connection
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mult_ctrl
  import cpu_types_pkg::*;
#(
  parameter int MUL_ITERS = 32
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   ex_valid,
  input  word_t  ex_porta,
  input  word_t  ex_portb,
  input  aluop_t ex_aluop,
  output word_t  ex_out,
  output logic   ex_zero,
  output logic   ex_ovf,
  output logic   ex_neg,
  input  logic   mul_start,
  input  logic   mul_signed,
  input  word_t  mul_a,
  input  word_t  mul_b,
  output logic   mul_busy,
  output logic   mul_done,
  output word_t  hi,
  output word_t  lo,
  alu_if.tb      aluif
);

  localparam logic [4:0] LAST_ITER = 5'(MUL_ITERS - 1);

  mulstate_t  state_q;
  word_t      a_q, p_hi_q, p_lo_q, hi_q, lo_q;
  logic [4:0] cnt_q;
  logic       neg_q, lo_zero_q, busy_q, done_q;

  // Multiplier's ALU request for the current state
  logic   mul_req;
  word_t  mul_pa, mul_pb;
  aluop_t mul_op;

  always_comb begin
    mul_req = 1'b0;
    mul_pa  = '0;
    mul_pb  = '0;
    mul_op  = ALU_ADD;
    case (state_q)
      ABS_A:  begin mul_req = 1'b1; mul_op = ALU_SUB; mul_pb = a_q; end
      ABS_B:  begin mul_req = 1'b1; mul_op = ALU_SUB; mul_pb = p_lo_q; end
      ITER:   begin mul_req = p_lo_q[0]; mul_pa = p_hi_q; mul_pb = a_q; end
      NEG_LO: begin mul_req = 1'b1; mul_op = ALU_SUB; mul_pb = p_lo_q; end
      NEG_HI: begin
        mul_req = 1'b1;
        // Low word zero means the +1 of the 64-bit negate carries into HI
        if (lo_zero_q) begin
          mul_op = ALU_SUB;
          mul_pb = p_hi_q;
        end else begin
          mul_op = ALU_NOR;
          mul_pa = p_hi_q;
          mul_pb = p_hi_q;
        end
      end
      default: ;
    endcase
  end

  logic grant;
  assign grant = mul_req & ~ex_valid;

  assign aluif.PORTA = grant ? mul_pa : ex_porta;
  assign aluif.PORTB = grant ? mul_pb : ex_portb;
  assign aluif.ALUOP = grant ? mul_op : ex_aluop;

  assign ex_out  = aluif.OUTPORT;
  assign ex_zero = aluif.ZERO;
  assign ex_ovf  = aluif.OVF;
  assign ex_neg  = aluif.NEG;

  // One shift-add step. The ADD's carry-out is recovered by unsigned
  // wrap detection because the ALU exposes no carry flag.
  logic  carry, iter_adv;
  word_t iter_hi, iter_lo;

  assign carry    = aluif.OUTPORT < p_hi_q;
  assign iter_adv = ~p_lo_q[0] | grant;
  assign iter_hi  = p_lo_q[0] ? {carry, aluif.OUTPORT[31:1]} : {1'b0, p_hi_q[31:1]};
  assign iter_lo  = p_lo_q[0] ? {aluif.OUTPORT[0], p_lo_q[31:1]} : {p_hi_q[0], p_lo_q[31:1]};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      a_q       <= '0;
      p_hi_q    <= '0;
      p_lo_q    <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      lo_zero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (mul_start) begin
          a_q     <= mul_a;
          p_lo_q  <= mul_b;
          p_hi_q  <= '0;
          cnt_q   <= '0;
          neg_q   <= mul_signed & (mul_a[31] ^ mul_b[31]);
          busy_q  <= 1'b1;
          state_q <= mul_signed ? ABS_A : ITER;
        end
        // 0x80000000 negates to itself, which is the correct unsigned magnitude
        ABS_A: if (grant) begin
          if (a_q[31]) a_q <= aluif.OUTPORT;
          state_q <= ABS_B;
        end
        ABS_B: if (grant) begin
          if (p_lo_q[31]) p_lo_q <= aluif.OUTPORT;
          state_q <= ITER;
        end
        ITER: if (iter_adv) begin
          p_hi_q <= iter_hi;
          p_lo_q <= iter_lo;
          cnt_q  <= cnt_q + 5'd1;
          if (cnt_q == LAST_ITER) begin
            if (neg_q) begin
              state_q <= NEG_LO;
            end else begin
              hi_q    <= iter_hi;
              lo_q    <= iter_lo;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        NEG_LO: if (grant) begin
          lo_zero_q <= (p_lo_q == '0);
          p_lo_q    <= aluif.OUTPORT;
          state_q   <= NEG_HI;
        end
        NEG_HI: if (grant) begin
          p_hi_q  <= aluif.OUTPORT;
          hi_q    <= aluif.OUTPORT;
          lo_q    <= p_lo_q;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mul_busy = busy_q;
  assign mul_done = done_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
`default_nettype wire

// File: doc/alu_mult_ctrl.md
# alu_mult_ctrl

Shares the single-cycle ALU between the execute stage and an iterative 32x32 multiplier, and sequences that multiplier.
- Pipeline ALU requests always win the ALU.
- The multiplier uses the ALU for input magnitudes, shift-add partial sums and result negation, and stalls in any cycle it is denied.
- Sits between the execute stage and the ALU instance; produces the 64-bit HI/LO result for MULT/MULTU.

## Interface

Parameters:
- MUL_ITERS, 32, shift-add iterations (equals word width)

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, synchronous, active-high
- ex_valid  in  1  execute stage needs the ALU this cycle
- ex_porta, ex_portb  in  32  execute operands (word_t)
- ex_aluop  in  aluop_t  execute operation
- ex_out  out  32  ALU OUTPORT, passed through combinationally
- ex_zero, ex_ovf, ex_neg  out  1  ALU flags, passed through combinationally
- mul_start  in  1  start request, sampled only in IDLE
- mul_signed  in  1  1 = MULT, 0 = MULTU; sampled with mul_start
- mul_a, mul_b  in  32  operands; sampled with mul_start
- mul_busy  out  1  high in every state except IDLE
- mul_done  out  1  one-cycle pulse in DONE
- hi, lo  out  32  last completed product
- aluif  alu_if.tb  —  drives PORTA/PORTB/ALUOP; reads OUTPORT/ZERO/OVF/NEG

## Operation

ALU port mux:
- ALU inputs = ex_* whenever ex_valid=1 or the multiplier is not requesting.
- Otherwise ALU inputs = multiplier operands.
- grant = mul_req & ~ex_valid.
- A multiplier state that needs the ALU holds all of its registers until granted.

Registers:
- a_r, P_hi, P_lo: working operand and partial product
- cnt: 5-bit iteration counter
- neg_r: result must be negated
- lo_zero_r: captured low-word-was-zero flag for NEG_HI

States:
- IDLE: on mul_start, latch a_r=mul_a, P_lo=mul_b, P_hi=0, cnt=0, neg_r=signed & (a[31]^b[31]). Next state is ABS_A if signed, else ITER.
- ABS_A: request ALU_SUB(0, a_r). On grant, a_r = a_r[31] ? OUTPORT : a_r.
- ABS_B: request ALU_SUB(0, P_lo). On grant, P_lo = P_lo[31] ? OUTPORT : P_lo.
- ITER, P_lo[0]=1:
  - Request ALU_ADD(P_hi, a_r).
  - On grant, carry = (OUTPORT < P_hi) as unsigned; {P_hi,P_lo} = {carry, OUTPORT, P_lo[31:1]}.
- ITER, P_lo[0]=0:
  - No ALU request; {P_hi,P_lo} = {1'b0, P_hi, P_lo[31:1]} every cycle, regardless of ex_valid.
- ITER, all cases: cnt increments on each advance; after the advance with cnt=31, go to NEG_LO if neg_r, else DONE.
- NEG_LO: request ALU_SUB(0, P_lo). On grant, lo_zero_r = (P_lo==0) and P_lo = OUTPORT.
- NEG_HI: request ALU_SUB(0, P_hi) if lo_zero_r, else ALU_NOR(P_hi, P_hi). On grant, P_hi = OUTPORT.
- DONE: hi=P_hi, lo=P_lo (registered on DONE entry); mul_done=1; next state IDLE.

Arithmetic and boundary rules:
- 0x80000000 magnitude stays 0x80000000 and is treated as unsigned 2^31.
- ALU OVF is ignored by the multiplier.
- mul_start outside IDLE (including DONE) is ignored.
- hi/lo hold their values until the next DONE.
- No starvation guard: ex_valid held high stalls ALU-needing multiplier states indefinitely.

## Timing

Reset values:
- RST=1 at any edge forces state IDLE, cnt=0.
- mul_busy=0, mul_done=0, hi=0, lo=0, all working registers 0.
- This applies mid-operation too; the aborted product is discarded.

Uncontended latency (start sampled at cycle 0):
- Unsigned: ITER occupies cycles 1–32; mul_done at cycle 33.
- Signed, no negation: ABS_A 1, ABS_B 2, ITER 3–34; mul_done at 35.
- Signed, with negation: NEG_LO 35, NEG_HI 36; mul_done at 37.

Contention and flags:
- Each denied cycle in ABS_A, ABS_B, NEG_LO, NEG_HI, or ITER with P_lo[0]=1 adds exactly one cycle.
- mul_busy falls in the cycle after DONE.
- A new start is accepted in that cycle at the earliest.

## Structure

- cpu_types_pkg gains mulstate_t (IDLE, ABS_A, ABS_B, ITER, NEG_LO, NEG_HI, DONE) and the constant MUL_ITERS.
- No sub-module: one FSM plus the port mux. The ALU is instantiated outside and reached via alu_if.

## Test plan

- Unsigned 3 × 5, ex_valid=0 → mul_done at cycle 33; hi=0x00000000, lo=0x0000000F.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001 (carry path every iteration).
- Signed −3 (0xFFFFFFFD) × 5 → mul_done at cycle 37; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Signed 0x80000000 × 0x80000000 → mul_done at cycle 35; hi=0x40000000, lo=0.
- ex_valid high for 10 cycles mid-ITER:
  - With mul_b=0xFFFFFFFF, done is delayed exactly 10 cycles.
  - With mul_b=0, there is no delay.
  - In both cases ex_out shows the ex operation result every one of those cycles.
- RST pulsed at cycle 12 of a multiply → next cycle mul_busy=0, hi=lo=0. mul_start during a busy multiply is ignored. A fresh 7 × 6 afterwards gives lo=42.
